// File: rtl/uart_pkg.sv
// Shared constants and send-FSM state encoding for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_WAIT = 2'b10
    } send_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with registered occupancy flags and sticky overflow.
// UART_TX_FIFO_DROP_CNT_EN adds a saturating counter of dropped pushes.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic                clr_ovf,
    output logic [DATA_W-1:0]   rd_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam logic [DEPTH_LOG2:0]   CNT_ZERO_C = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE_C  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   DEPTH_C    = CNT_ONE_C << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO_C = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C  = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem_r [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  overflow_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;

    // A push into a full FIFO still lands when the same cycle frees a slot.
    always_comb begin
        pop_s  = rd_en & ~empty_r;
        push_s = wr_en & (~full_r | pop_s);
        drop_s = wr_en & ~push_s;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE_C;
            2'b01:   count_s = count_r - CNT_ONE_C;
            default: count_s = count_r;
        endcase
    end

    // Pointers, occupancy flags and sticky overflow (clear wins over set).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= PTR_ZERO_C;
            rd_ptr_r   <= PTR_ZERO_C;
            count_r    <= CNT_ZERO_C;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_C);
            empty_r <= (count_s == CNT_ZERO_C);
            if (clr_ovf)     overflow_r <= 1'b0;
            else if (drop_s) overflow_r <= 1'b1;
        end
    end

    // Storage array; deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= wr_data;
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating dropped-push counter, cleared together with overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'h0000;
        end else if (clr_ovf) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus send sequencer feeding uart_tx through its SEND/DATA/READY handshake.
// Optional build macro UART_TX_FIFO_DROP_CNT_EN exposes a 16-bit dropped-push counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    input  logic                clr_ovf,
    output logic                tx_send,
    output logic [DATA_W-1:0]   tx_data,
    input  logic                tx_ready,
    output logic                busy
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    send_state_e       state_r;
    send_state_e       state_s;
    logic              pop_s;
    logic              empty_s;
    logic              tx_send_s;
    logic              tx_send_r;
    logic [DATA_W-1:0] tx_data_s;
    logic [DATA_W-1:0] tx_data_r;
    logic [DATA_W-1:0] rd_data_s;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data_s),
        .full     (full),
        .empty    (empty_s),
        .count    (count),
        .overflow (overflow)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            tx_send_r <= 1'b0;
            tx_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_s;
            tx_send_r <= tx_send_s;
            tx_data_r <= tx_data_s;
        end
    end

    // SEND is a level held until uart_tx acknowledges by dropping READY.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!empty_s && tx_ready) state_s = S_SEND;
                else                      state_s = S_IDLE;
            end
            S_SEND: begin
                if (!tx_ready) state_s = S_WAIT;
                else           state_s = S_SEND;
            end
            S_WAIT: begin
                if (tx_ready) state_s = S_IDLE;
                else          state_s = S_WAIT;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Pop the head exactly once, on the IDLE->SEND transition.
    always_comb begin
        pop_s     = 1'b0;
        tx_data_s = tx_data_r;
        tx_send_s = (state_s == S_SEND);
        if ((state_r == S_IDLE) && !empty_s && tx_ready) begin
            pop_s     = 1'b1;
            tx_data_s = rd_data_s;
        end else begin
            pop_s     = 1'b0;
            tx_data_s = tx_data_r;
        end
    end

    assign empty   = empty_s;
    assign tx_send = tx_send_r;
    assign tx_data = tx_data_r;
    assign busy    = (state_r != S_IDLE) | ~empty_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural uart_tx responder.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    uart_tx_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // uart_tx responder state
    logic       uart_auto   = 1'b0;
    logic       rand_timing = 1'b0;
    logic       man_ready   = 1'b1;
    logic       model_ready = 1'b1;
    logic       prev_send   = 1'b0;
    int         busy_cnt    = 0;
    int         hold_cnt    = 0;
    int         rises       = 0;
    logic [7:0] frames[$];
    logic [7:0] exp_q[$];

    assign tx_ready = uart_auto ? model_ready : man_ready;

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_data;
        logic        tx_ready;
        logic [15:0] exp;      // {tx_send, tx_data, count, empty, busy}
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic we, input logic [7:0] d, input logic rdy,
                                input logic s, input logic [7:0] td, input logic [4:0] c,
                                input logic e, input logic b);
        vec_t v;
        v.wr_en    = we;
        v.wr_data  = d;
        v.tx_ready = rdy;
        v.exp      = {s, td, c, e, b};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 400 && (busy !== 1'b0 || busy_cnt != 0); n++) tick();
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frames(input string name, input int fb);
        logic [7:0] got;
        check({name, "_nframes"}, frames.size() - fb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (fb + i < frames.size()) ? frames[fb + i] : 8'hxx;
            check($sformatf("%s_frame%0d", name, i), {24'd0, got}, {24'd0, exp_q[i]});
        end
    endtask

    // Behavioural uart_tx: accepts SEND while idle, then holds READY low for one frame.
    always begin
        @(posedge clk);
        #1;
        if (tx_send && !prev_send) rises++;
        prev_send = tx_send;
        if (uart_auto) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) model_ready = 1'b1;
            end else if (tx_send && model_ready) begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                end else begin
                    frames.push_back(tx_data);
                    model_ready = 1'b0;
                    busy_cnt    = rand_timing ? int'($urandom_range(2, 12)) : 10;
                    hold_cnt    = rand_timing ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
    end

    initial begin
        int fb;
        int rb;
        int nb;
        logic [7:0] d;

        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        man_ready = 1'b1; uart_auto = 1'b0;

        // Single push/send latency, 5-cycle READY hold, push-while-idle-sees-empty.
        vecs[0]  = mk(1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b1);
        vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 8'h55, 1'b1, 1'b0, 8'h41, 5'd1, 1'b0, 1'b1);
        vecs[11] = mk(1'b1, 8'h66, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0, 1'b1);
        vecs[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 5'd1, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 5'd1, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h66, 5'd0, 1'b1, 1'b1);
        vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 5'd0, 1'b1, 1'b1);
        vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h66, 5'd0, 1'b1, 1'b0);

        repeat (3) tick();
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; man_ready = vecs[i].tx_ready;
            tick();
            check($sformatf("vec%0d", i), {16'd0, tx_send, tx_data, count, empty, busy},
                  {16'd0, vecs[i].exp});
        end
        wr_en = 1'b0; man_ready = 1'b1;

        // Ordered send through the responder
        uart_auto = 1'b1; fb = frames.size(); rb = rises;
        exp_q = '{8'h41, 8'h42, 8'h43};
        foreach (exp_q[i]) begin
            wr_en = 1'b1; wr_data = exp_q[i]; tick();
        end
        wr_en = 1'b0;
        for (int n = 0; n < 300 && frames.size() - fb < 3; n++) tick();
        wait_idle("ord_idle");
        check_frames("ord", fb);
        check("ord_rises", rises - rb, 32'd3);
        check("ord_empty", {31'd0, empty}, 32'd1);

        // Overflow with READY held low
        uart_auto = 1'b0; man_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = i[7:0]; tick();
            if (i == 15) check("ovf_before_drop", {31'd0, overflow}, 32'd0);
        end
        wr_en = 1'b0;
        check("ovf_count", {27'd0, count}, 32'd16);
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_no_send", {31'd0, tx_send}, 32'd0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        check("drop_cnt_one", {16'd0, drop_cnt}, 32'd1);
`endif
        wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
        tick();
        wr_en = 1'b0; clr_ovf = 1'b0;
        check("clr_priority", {31'd0, overflow}, 32'd0);
        check("clr_count", {27'd0, count}, 32'd16);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        check("drop_cnt_clr", {16'd0, drop_cnt}, 32'd0);
`endif
        tick();
        check("clr_stays", {31'd0, overflow}, 32'd0);

        // Full FIFO: release READY and push 0xAA in the pop cycle
        fb = frames.size(); rb = rises;
        man_ready = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("fp_count", {27'd0, count}, 32'd16);
        check("fp_full", {31'd0, full}, 32'd1);
        check("fp_overflow", {31'd0, overflow}, 32'd0);
        check("fp_send", {31'd0, tx_send}, 32'd1);
        check("fp_head", {24'd0, tx_data}, 32'd0);
        uart_auto = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(i[7:0]);
        exp_q.push_back(8'hAA);
        for (int n = 0; n < 1500 && frames.size() - fb < 17; n++) tick();
        wait_idle("fp_idle");
        check_frames("fp", fb);
        check("fp_rises", rises - rb, 32'd17);

        // Reset in S_SEND with three bytes queued
        uart_auto = 1'b0; man_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + i[7:0]; tick();
        end
        wr_en = 1'b0;
        check("rm_count", {27'd0, count}, 32'd3);
        check("rm_send", {31'd0, tx_send}, 32'd1);
        check("rm_data", {24'd0, tx_data}, 32'hC0);
        #2 rst_n = 1'b0;
        #1;
        check("rm_send_async", {31'd0, tx_send}, 32'd0);
        check("rm_count_async", {27'd0, count}, 32'd0);
        check("rm_empty_async", {31'd0, empty}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        fb = frames.size(); rb = rises;
        uart_auto = 1'b1;
        repeat (60) tick();
        check("rm_no_frames", frames.size() - fb, 32'd0);
        check("rm_no_rises", rises - rb, 32'd0);
        check("rm_empty", {31'd0, empty}, 32'd1);
        check("rm_busy", {31'd0, busy}, 32'd0);

        // Wrap-around: 40 bytes in bursts of 7, randomized gaps and uart timing
        rand_timing = 1'b1; fb = frames.size(); rb = rises; nb = 0;
        exp_q.delete();
        for (int b = 0; b < 6; b++) begin
            for (int n = 0; n < 500 && count > 5'd9; n++) tick();
            repeat ($urandom_range(0, 6)) tick();
            for (int k = 0; k < 7 && nb < 40; k++) begin
                wr_en = 1'b1; wr_data = nb[7:0]; exp_q.push_back(nb[7:0]); nb++;
                tick();
            end
            wr_en = 1'b0;
        end
        // Random bytes at random rate, throttled below full
        for (int n = 0; n < 2000 && nb < 70; n++) begin
            d = 8'($urandom);
            wr_en = (count < 5'd12) && ($urandom_range(0, 1) == 1);
            wr_data = d;
            if (wr_en) begin
                exp_q.push_back(d);
                nb++;
            end
            tick();
        end
        wr_en = 1'b0;
        for (int n = 0; n < 3000 && frames.size() - fb < exp_q.size(); n++) tick();
        wait_idle("wrap_idle");
        check_frames("wrap", fb);
        check("wrap_rises", rises - rb, exp_q.size());
        check("wrap_overflow", {31'd0, overflow}, 32'd0);
        check("wrap_empty", {31'd0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
